// File: rtl/gate_truth_table_checker.sv
// gate_truth_table_checker
//   Self-test engine for a 2-input gate. On start it drives the vectors
//   00, 01, 10, 11 onto the gate, holds each for HOLD_CYCLES cycles, samples
//   the gate output on the last edge of each hold and compares it with
//   EXPECT_MASK[{input_1,input_2}]. All outputs are registered.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   start      : run request, only looked at while idle
//   input_1    : stimulus, MSB of vector index
//   input_2    : stimulus, LSB of vector index
//   and_result : gate response under check
//   busy       : run in progress
//   done       : one-cycle pulse when a run completes
//   pass       : last completed run had no mismatches
//   err_count  : saturating mismatch count for the last/current run
//   fail_vec   : bit v set when vector v mismatched
module gate_truth_table_checker #(
    parameter int         HOLD_CYCLES = 10,
    parameter logic [3:0] EXPECT_MASK = 4'b1000,
    parameter int         ERR_W       = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             input_1,
    output logic             input_2,
    input  logic             and_result,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [3:0]       fail_vec
);

    localparam int               CNT_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    typedef enum logic {IDLE, DRIVE} state_t;

    state_t           state_q, state_d;
    logic [1:0]       v_q, v_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       vec_d;
    logic             busy_d, done_d, pass_d;
    logic [ERR_W-1:0] err_d;
    logic [3:0]       fail_d;
    logic             mismatch;

    // Case inequality so an unknown response is flagged rather than
    // silently matching in simulation.
    assign mismatch = (and_result !== EXPECT_MASK[v_q]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            v_q       <= 2'b00;
            cnt_q     <= '0;
            input_1   <= 1'b0;
            input_2   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_vec  <= 4'b0000;
        end else begin
            state_q   <= state_d;
            v_q       <= v_d;
            cnt_q     <= cnt_d;
            input_1   <= vec_d[1];
            input_2   <= vec_d[0];
            busy      <= busy_d;
            done      <= done_d;
            pass      <= pass_d;
            err_count <= err_d;
            fail_vec  <= fail_d;
        end
    end

    always_comb begin
        state_d = state_q;
        v_d     = v_q;
        cnt_d   = cnt_q;
        busy_d  = busy;
        done_d  = 1'b0;
        pass_d  = pass;
        err_d   = err_count;
        fail_d  = fail_vec;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    state_d = DRIVE;
                    v_d     = 2'b00;
                    cnt_d   = CNT_LOAD;
                    busy_d  = 1'b1;
                    pass_d  = 1'b0;
                    err_d   = '0;
                    fail_d  = 4'b0000;
                end
            end
            DRIVE: begin
                if (cnt_q == '0) begin
                    if (mismatch) begin
                        fail_d[v_q] = 1'b1;
                        if (err_count != ERR_MAX)
                            err_d = err_count + ERR_W'(1);
                    end
                    if (v_q == 2'd3) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        // fail_d already includes this last sample; it is
                        // used instead of err_d so saturation cannot hide errors.
                        pass_d  = (fail_d == 4'b0000);
                    end else begin
                        v_d   = v_q + 2'd1;
                        cnt_d = CNT_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Stimulus is registered, so it follows the next vector index.
        vec_d = (state_d == DRIVE) ? v_d : 2'b00;
    end

endmodule

// File: tb/tb_gate_truth_table_checker.sv
module tb_gate_truth_table_checker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       sel;          // 0: default instance, 1: short/XOR instance
    logic [3:0] gate_tt;      // behaviour of the gate under test, indexed by vector

    // instance 0: defaults (HOLD 10, AND table, ERR_W 3)
    logic       in1_0, in2_0, res_0, busy_0, done_0, pass_0;
    logic [2:0] err_0;
    logic [3:0] fail_0;
    // instance 1: HOLD 1, XOR table, ERR_W 1
    logic       in1_1, in2_1, res_1, busy_1, done_1, pass_1;
    logic [0:0] err_1;
    logic [3:0] fail_1;

    logic [1:0] o_vec;
    logic       o_busy, o_done, o_pass;
    logic [7:0] o_err;
    logic [3:0] o_fail;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    assign res_0 = gate_tt[{in1_0, in2_0}];
    assign res_1 = gate_tt[{in1_1, in2_1}];

    gate_truth_table_checker u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start & ~sel),
        .input_1(in1_0), .input_2(in2_0), .and_result(res_0),
        .busy(busy_0), .done(done_0), .pass(pass_0),
        .err_count(err_0), .fail_vec(fail_0)
    );

    gate_truth_table_checker #(
        .HOLD_CYCLES(1), .EXPECT_MASK(4'b0110), .ERR_W(1)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start & sel),
        .input_1(in1_1), .input_2(in2_1), .and_result(res_1),
        .busy(busy_1), .done(done_1), .pass(pass_1),
        .err_count(err_1), .fail_vec(fail_1)
    );

    always_comb begin
        if (sel) begin
            o_vec = {in1_1, in2_1}; o_busy = busy_1; o_done = done_1;
            o_pass = pass_1; o_err = {7'b0, err_1}; o_fail = fail_1;
        end else begin
            o_vec = {in1_0, in2_0}; o_busy = busy_0; o_done = done_0;
            o_pass = pass_0; o_err = {5'b0, err_0}; o_fail = fail_0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    endtask

    // One full run on the selected instance. The gate truth table tt is
    // compared with the instance's expected table: every differing vector is
    // a failure. repulse >= 0 raises start for one cycle at that hold cycle;
    // chain leaves start high in the done cycle so the next run follows.
    task automatic run(input logic [3:0] tt, input int repulse, input bit chain);
        int         h, emax, ee;
        logic [3:0] ef;
        h    = sel ? 1 : 10;
        emax = sel ? 1 : 7;
        ef   = tt ^ (sel ? 4'b0110 : 4'b1000);
        ee   = $countones(ef);
        if (ee > emax) ee = emax;
        gate_tt = tt;
        start   = 1'b1;
        for (int k = 0; k < 4 * h; k++) begin
            @(negedge clk);
            start = (k == repulse);
            chk("vec", {30'b0, o_vec}, k / h);
            chk("busy_run", {31'b0, o_busy}, 1);
            chk("done_early", {31'b0, o_done}, 0);
            if (k == 0) begin
                chk("clr_err", {24'b0, o_err}, 0);
                chk("clr_fail", {28'b0, o_fail}, 0);
                chk("clr_pass", {31'b0, o_pass}, 0);
            end
        end
        @(negedge clk);
        start = chain;
        chk("done", {31'b0, o_done}, 1);
        chk("busy_end", {31'b0, o_busy}, 0);
        chk("vec_idle", {30'b0, o_vec}, 0);
        chk("pass", {31'b0, o_pass}, (ef == 4'b0000) ? 1 : 0);
        chk("err", {24'b0, o_err}, ee);
        chk("fail", {28'b0, o_fail}, ef);
        if (!chain) begin
            @(negedge clk);
            chk("done_pulse", {31'b0, o_done}, 0);
            chk("hold_err", {24'b0, o_err}, ee);
            chk("hold_fail", {28'b0, o_fail}, ef);
        end
    endtask

    initial begin
        rst_n   = 1'b1;
        start   = 1'b0;
        sel     = 1'b0;
        gate_tt = 4'b1000;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_vec", {30'b0, o_vec}, 0);
        chk("rst_busy", {31'b0, o_busy}, 0);
        chk("rst_done", {31'b0, o_done}, 0);
        chk("rst_pass", {31'b0, o_pass}, 0);
        chk("rst_err", {24'b0, o_err}, 0);
        chk("rst_fail", {28'b0, o_fail}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // correct AND gate, stuck-at-1, re-pulse ignored, back-to-back
        run(4'b1000, -1, 1'b0);
        run(4'b1111, -1, 1'b0);
        run(4'b1000, 5, 1'b0);
        run(4'b1000, -1, 1'b1);
        run(4'b1111, -1, 1'b0);

        // reset mid-run at hold cycle 15, checked between clock edges
        gate_tt = 4'b1000;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_vec", {30'b0, o_vec}, 0);
        chk("abort_busy", {31'b0, o_busy}, 0);
        chk("abort_done", {31'b0, o_done}, 0);
        chk("abort_err", {24'b0, o_err}, 0);
        chk("abort_fail", {28'b0, o_fail}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 45; k++) begin
            @(negedge clk);
            chk("idle_busy", {31'b0, o_busy}, 0);
            chk("idle_done", {31'b0, o_done}, 0);
        end
        run(4'b1000, -1, 1'b0);

        // random gates on the default instance
        repeat (6) run(4'($urandom), -1, 1'b0);

        // HOLD 1 / XOR table / 1-bit saturating counter
        sel = 1'b1;
        @(negedge clk);
        run(4'b1000, -1, 1'b0);
        run(4'b1111, -1, 1'b0);
        run(4'b0110, -1, 1'b1);
        run(4'b0001, -1, 1'b0);
        repeat (20) run(4'($urandom), -1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/gate_truth_table_checker.md
Name: gate_truth_table_checker

Overview:
- Sequential self-checking stimulus/response engine for a 2-input gate DUT; acts as the hardware counterpart of a 2-input gate testbench.
- On start, drives all four input vectors onto the DUT in order 00, 01, 10, 11 and holds each for a fixed number of cycles.
- Samples the DUT output at the end of each hold and compares it against a parameterised truth table.
- Reports pass/fail, an error count and a per-vector failure mask.
- Sits beside the gate under test in on-chip sampling/self-test builds.

Parameters:
- HOLD_CYCLES, 10, clock cycles each vector is driven (legal range >= 1).
- EXPECT_MASK, 4'b1000, expected DUT output indexed by vector v = {input_1,input_2}. Default is the AND truth table.
- ERR_W, 3, width of the error counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- start  input  1  request a check run; sampled only in IDLE.
- input_1  output  1  DUT stimulus, MSB of the vector index.
- input_2  output  1  DUT stimulus, LSB of the vector index.
- and_result  input  1  DUT response under check.
- busy  output  1  high while a run is in progress.
- done  output  1  one-cycle pulse at run completion.
- pass  output  1  high when the last completed run had zero mismatches.
- err_count  output  ERR_W  mismatch count for the last or current run.
- fail_vec  output  4  bit v set when vector v mismatched.

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset:
  - State goes to IDLE immediately on rst_n low, independent of clk.
  - input_1, input_2, busy, done, pass all 0; err_count = 0; fail_vec = 0.
- All outputs are registered.
- States: IDLE, DRIVE.
- IDLE:
  - input_1 = input_2 = 0; busy = 0.
  - pass, err_count and fail_vec hold the previous result.
  - If start = 1 at a clock edge: go to DRIVE with v = 0 and hold counter = HOLD_CYCLES-1. Set busy = 1 and clear pass, err_count and fail_vec at that same edge.
- DRIVE:
  - {input_1,input_2} = v.
  - Hold counter decrements every cycle.
  - At the edge where the counter is 0, sample and_result.
    - Mismatch vs EXPECT_MASK[v]: set fail_vec[v] and increment err_count.
    - err_count saturates at 2^ERR_W-1.
    - In simulation, X/Z on and_result counts as a mismatch.
  - Same edge, v < 3: advance v and reload the counter to HOLD_CYCLES-1.
  - Same edge, v = 3: go to IDLE, busy = 0, done = 1 for exactly one cycle, pass = (no mismatches including this sample).
- Latency:
  - The done cycle begins exactly 4*HOLD_CYCLES edges after the start-accept edge.
  - Each vector is visible for exactly HOLD_CYCLES cycles.
- HOLD_CYCLES = 1: each vector lasts one cycle and is sampled at the end of that cycle. No idle gap between vectors.
- start while busy: ignored, no effect on the sequence or the result.
- start high in the done cycle: accepted, because the state is already IDLE. A new run begins at the next edge and the result is cleared at that edge.
- start held high continuously: runs repeat back-to-back with one IDLE/done cycle between runs.
- rst_n asserted mid-run: the run is aborted, no done pulse is issued and the result is cleared. After release the block stays in IDLE until the next start.

Test Plan:
1. Correct AND DUT, defaults, start pulse at edge 0 -> vectors 00/01/10/11 each held 10 cycles; done for one cycle starting 40 edges later; pass = 1, err_count = 0, fail_vec = 4'b0000.
2. DUT output stuck at 1 -> err_count = 3, fail_vec = 4'b0111, pass = 0.
3. EXPECT_MASK = 4'b0110 (XOR table) with a correct AND DUT -> fail_vec = 4'b1110, err_count = 3, pass = 0.
4. ERR_W = 1 with stuck-at-1 DUT -> err_count saturates at 1, fail_vec = 4'b0111; HOLD_CYCLES = 1 run completes with done 4 edges after accept.
5. start re-pulsed at cycle 5 of a run -> ignored, done still at edge 40; start high in the done cycle -> new run, outputs cleared at the next edge, second done 41 edges after the first.
6. rst_n low at cycle 15 of a run -> all outputs 0 without waiting for a clock edge, no done; after release, block idles until start, then a full run passes.
